// File: rtl/lc_tx_sequencer.sv
// lc_tx_sequencer
// Transmit-side sequencer for the layer controller. Takes a 1..BUF_SIZE word
// message command from layer logic and drives the MBus TX port. Words are
// chained with TX_PEND, and each word uses a 4-phase TX_REQ/TX_ACK handshake.
// The MBus result (TX_SUCC/TX_FAIL) is acknowledged with TX_RESP_ACK, and
// completion is reported upstream with a one-cycle DONE pulse.
//
// Handshakes (all 4-phase, level based):
//   CMD_REQ/CMD_ACK     : CMD_ACK rises when the command is latched. It falls
//                         on the first cycle CMD_REQ is low. A new command
//                         needs CMD_REQ low first.
//   TX_REQ/TX_ACK       : TX_REQ falls once TX_ACK is seen. The next word is
//                         raised only after TX_ACK has returned low.
//                         TX_DATA/TX_PEND change only while TX_REQ is low.
//   TX_SUCC|TX_FAIL /
//   TX_RESP_ACK         : TX_RESP_ACK is held until both result lines drop.
//
// Ports:
//   CLK, resetn_local         clock, async active-low reset
//   CMD_REQ/ACK/ADDR/LEN/DATA/PRIORITY   upstream command
//   DONE, DONE_FAIL, DONE_WORDS          upstream completion report
//   TX_ADDR/DATA/PEND/REQ/ACK, PRIORITY  MBus TX word interface
//   TX_SUCC, TX_FAIL, TX_RESP_ACK        MBus TX result interface
//   state_dbg_o                          current FSM state (debug)
module lc_tx_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 4,
  localparam int LW = $clog2(BUF_SIZE),
  localparam int CW = $clog2(BUF_SIZE + 1)
) (
  input  logic                         CLK,
  input  logic                         resetn_local,
  input  logic                         CMD_REQ,
  output logic                         CMD_ACK,
  input  logic [ADDR_WIDTH-1:0]        CMD_ADDR,
  input  logic [LW-1:0]                CMD_LEN,
  input  logic [DATA_WIDTH*BUF_SIZE-1:0] CMD_DATA,
  input  logic                         CMD_PRIORITY,
  output logic                         DONE,
  output logic                         DONE_FAIL,
  output logic [CW-1:0]                DONE_WORDS,
  output logic [ADDR_WIDTH-1:0]        TX_ADDR,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic                         TX_PEND,
  output logic                         TX_REQ,
  input  logic                         TX_ACK,
  output logic                         PRIORITY,
  input  logic                         TX_SUCC,
  input  logic                         TX_FAIL,
  output logic                         TX_RESP_ACK,
  output logic [2:0]                   state_dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ACK_LOW = 3'd2,
    ST_RESULT  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   words_q [BUF_SIZE];
  logic [DATA_WIDTH-1:0]   words_d [BUF_SIZE];
  logic [LW-1:0]           len_q, len_d, idx_q, idx_d;
  logic [CW-1:0]           acked_q, acked_d;
  logic                    fail_q, fail_d;
  logic                    cmd_ack_q, cmd_ack_d;
  logic [ADDR_WIDTH-1:0]   tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_pend_q, tx_pend_d;
  logic                    tx_req_q, tx_req_d;
  logic                    prio_q, prio_d;
  logic                    resp_ack_q, resp_ack_d;
  logic                    done_q, done_d;
  logic                    done_fail_q, done_fail_d;
  logic [CW-1:0]           done_words_q, done_words_d;

  logic          accept;
  logic          result;
  logic [LW-1:0] idx_next;

  // CMD_ACK must be low before a new command is taken, so a CMD_REQ still
  // held from the previous message cannot retrigger.
  assign accept   = (state_q == ST_IDLE) && CMD_REQ && !cmd_ack_q;
  // Both result lines high counts as a failure; fail_d samples TX_FAIL.
  assign result   = TX_SUCC | TX_FAIL;
  assign idx_next = idx_q + LW'(1);

  // State and datapath registers
  always_ff @(posedge CLK or negedge resetn_local) begin
    if (!resetn_local) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < BUF_SIZE; i++) words_q[i] <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      acked_q      <= '0;
      fail_q       <= 1'b0;
      cmd_ack_q    <= 1'b0;
      tx_addr_q    <= '0;
      tx_data_q    <= '0;
      tx_pend_q    <= 1'b0;
      tx_req_q     <= 1'b0;
      prio_q       <= 1'b0;
      resp_ack_q   <= 1'b0;
      done_q       <= 1'b0;
      done_fail_q  <= 1'b0;
      done_words_q <= '0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      acked_q      <= acked_d;
      fail_q       <= fail_d;
      cmd_ack_q    <= cmd_ack_d;
      tx_addr_q    <= tx_addr_d;
      tx_data_q    <= tx_data_d;
      tx_pend_q    <= tx_pend_d;
      tx_req_q     <= tx_req_d;
      prio_q       <= prio_d;
      resp_ack_q   <= resp_ack_d;
      done_q       <= done_d;
      done_fail_q  <= done_fail_d;
      done_words_q <= done_words_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (TX_ACK)      state_d = ST_ACK_LOW;
        else if (result) state_d = ST_RESP;
      end
      ST_ACK_LOW: begin
        if (result)       state_d = ST_RESP;
        else if (!TX_ACK) state_d = (idx_q < len_q) ? ST_REQ : ST_RESULT;
      end
      ST_RESULT:  if (result)  state_d = ST_RESP;
      ST_RESP:    if (!result) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    words_d      = words_q;
    len_d        = len_q;
    idx_d        = idx_q;
    acked_d      = acked_q;
    fail_d       = fail_q;
    tx_addr_d    = tx_addr_q;
    tx_data_d    = tx_data_q;
    tx_pend_d    = tx_pend_q;
    tx_req_d     = tx_req_q;
    prio_d       = prio_q;
    resp_ack_d   = resp_ack_q;
    done_d       = 1'b0;
    done_fail_d  = done_fail_q;
    done_words_d = done_words_q;
    cmd_ack_d    = !CMD_REQ ? 1'b0 : (accept ? 1'b1 : cmd_ack_q);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          for (int i = 0; i < BUF_SIZE; i++)
            words_d[i] = CMD_DATA[i*DATA_WIDTH +: DATA_WIDTH];
          len_d     = CMD_LEN;
          idx_d     = '0;
          acked_d   = '0;
          fail_d    = 1'b0;
          tx_addr_d = CMD_ADDR;
          tx_data_d = CMD_DATA[DATA_WIDTH-1:0];
          tx_pend_d = (CMD_LEN != '0);
          prio_d    = CMD_PRIORITY;
          tx_req_d  = 1'b1;
        end
      end
      ST_REQ: begin
        if (TX_ACK) begin
          tx_req_d = 1'b0;
          acked_d  = acked_q + CW'(1);
        end else if (result) begin
          // Result before the word was acked: abort the message.
          tx_req_d   = 1'b0;
          tx_pend_d  = 1'b0;
          resp_ack_d = 1'b1;
          fail_d     = TX_FAIL;
        end
      end
      ST_ACK_LOW: begin
        if (result) begin
          tx_req_d   = 1'b0;
          tx_pend_d  = 1'b0;
          resp_ack_d = 1'b1;
          fail_d     = TX_FAIL;
        end else if (!TX_ACK) begin
          if (idx_q < len_q) begin
            idx_d     = idx_next;
            tx_data_d = words_q[idx_next];
            tx_pend_d = (idx_next != len_q);
            tx_req_d  = 1'b1;
          end else begin
            tx_pend_d = 1'b0;
          end
        end
      end
      ST_RESULT: begin
        if (result) begin
          resp_ack_d = 1'b1;
          fail_d     = TX_FAIL;
        end
      end
      ST_RESP: begin
        if (!result) begin
          resp_ack_d   = 1'b0;
          prio_d       = 1'b0;
          done_d       = 1'b1;
          // A short word count means the message was truncated.
          done_fail_d  = fail_q | (acked_q != (CW'(len_q) + CW'(1)));
          done_words_d = acked_q;
        end
      end
      default: ;
    endcase
  end

  assign CMD_ACK     = cmd_ack_q;
  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_PEND     = tx_pend_q;
  assign TX_REQ      = tx_req_q;
  assign PRIORITY    = prio_q;
  assign TX_RESP_ACK = resp_ack_q;
  assign DONE        = done_q;
  assign DONE_FAIL   = done_fail_q;
  assign DONE_WORDS  = done_words_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lc_tx_sequencer.sv
// Directed testbench for lc_tx_sequencer. Acts as both the upstream command
// source and the MBus node. Expected words sit in exp_q.
module tb_lc_tx_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BS = 4;

  logic          CLK;
  logic          resetn_local;
  logic          CMD_REQ;
  logic          CMD_ACK;
  logic [AW-1:0] CMD_ADDR;
  logic [1:0]    CMD_LEN;
  logic [DW*BS-1:0] CMD_DATA;
  logic          CMD_PRIORITY;
  logic          DONE;
  logic          DONE_FAIL;
  logic [2:0]    DONE_WORDS;
  logic [AW-1:0] TX_ADDR;
  logic [DW-1:0] TX_DATA;
  logic          TX_PEND;
  logic          TX_REQ;
  logic          TX_ACK;
  logic          PRIORITY;
  logic          TX_SUCC;
  logic          TX_FAIL;
  logic          TX_RESP_ACK;
  logic [2:0]    state_dbg;

  lc_tx_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_SIZE(BS)) dut (
    .CLK(CLK), .resetn_local(resetn_local),
    .CMD_REQ(CMD_REQ), .CMD_ACK(CMD_ACK), .CMD_ADDR(CMD_ADDR),
    .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA), .CMD_PRIORITY(CMD_PRIORITY),
    .DONE(DONE), .DONE_FAIL(DONE_FAIL), .DONE_WORDS(DONE_WORDS),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND),
    .TX_REQ(TX_REQ), .TX_ACK(TX_ACK), .PRIORITY(PRIORITY),
    .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr;
  logic          exp_prio;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required end of test before limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return TX_REQ;
      1:       return TX_RESP_ACK;
      default: return DONE;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (cur(sel) !== lvl && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {63'b0, cur(sel)}, {63'b0, lvl});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {57'b0, CMD_ACK, TX_REQ, TX_PEND, PRIORITY,
                               TX_RESP_ACK, DONE, DONE_FAIL}, 64'h0);
    check_eq({tag, "_addr"}, {32'b0, TX_ADDR}, 64'h0);
    check_eq({tag, "_data"}, {32'b0, TX_DATA}, 64'h0);
    check_eq({tag, "_words"}, {61'b0, DONE_WORDS}, 64'h0);
    check_eq({tag, "_state"}, {61'b0, state_dbg}, 64'h0);
  endtask

  // ---------------- drivers ----------------
  task automatic issue_cmd(input logic [AW-1:0] addr, input logic [1:0] len,
                           input logic [DW*BS-1:0] data, input logic prio,
                           input logic keep_req);
    CMD_ADDR     = addr;
    CMD_LEN      = len;
    CMD_DATA     = data;
    CMD_PRIORITY = prio;
    CMD_REQ      = 1'b1;
    exp_addr     = addr;
    exp_prio     = prio;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(data[i*DW +: DW]);
    tick();
    // First TX_REQ is expected one cycle after CMD_REQ.
    check_eq("cmd_ack_rise", {63'b0, CMD_ACK}, 64'h1);
    check_eq("first_tx_req", {63'b0, TX_REQ}, 64'h1);
    check_eq("priority_start", {63'b0, PRIORITY}, {63'b0, prio});
    if (!keep_req) CMD_REQ = 1'b0;
  endtask

  // MBus node side of one word: ack it and hold TX_ACK for 'hold' cycles.
  task automatic mbus_word(input int hold);
    logic [DW-1:0] w;
    logic          p;
    wait_level(0, 1'b1, "tx_req_rise");
    w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    p = (exp_q.size() != 0);
    check_eq("tx_data", {32'b0, TX_DATA}, {32'b0, w});
    check_eq("tx_pend", {63'b0, TX_PEND}, {63'b0, p});
    check_eq("tx_addr", {32'b0, TX_ADDR}, {32'b0, exp_addr});
    TX_ACK = 1'b1;
    tick();
    check_eq("tx_req_fall", {63'b0, TX_REQ}, 64'h0);
    for (int i = 1; i < hold; i++) begin
      tick();
      check_eq("hold_req_low", {63'b0, TX_REQ}, 64'h0);
      check_eq("hold_data", {32'b0, TX_DATA}, {32'b0, w});
    end
    TX_ACK = 1'b0;
    tick();
  endtask

  // MBus node result phase, then upstream completion report.
  task automatic mbus_result(input logic succ, input logic fail,
                             input logic [2:0] exp_words, input logic exp_fail);
    TX_SUCC = succ;
    TX_FAIL = fail;
    tick();
    check_eq("resp_ack_rise", {63'b0, TX_RESP_ACK}, 64'h1);
    check_eq("resp_req_pend", {62'b0, TX_REQ, TX_PEND}, 64'h0);
    check_eq("resp_no_done", {63'b0, DONE}, 64'h0);
    check_eq("resp_priority", {63'b0, PRIORITY}, {63'b0, exp_prio});
    tick();
    check_eq("resp_ack_hold", {63'b0, TX_RESP_ACK}, 64'h1);
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    tick();
    check_eq("done_pulse", {63'b0, DONE}, 64'h1);
    check_eq("done_fail", {63'b0, DONE_FAIL}, {63'b0, exp_fail});
    check_eq("done_words", {61'b0, DONE_WORDS}, {61'b0, exp_words});
    check_eq("resp_ack_fall", {63'b0, TX_RESP_ACK}, 64'h0);
    check_eq("priority_end", {63'b0, PRIORITY}, 64'h0);
    tick();
    check_eq("done_one_cycle", {63'b0, DONE}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn_local = 1'b0;
    CMD_REQ = 1'b0; CMD_ADDR = '0; CMD_LEN = '0; CMD_DATA = '0;
    CMD_PRIORITY = 1'b0; TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    exp_addr = '0; exp_prio = 1'b0;
    repeat (3) tick();
    resetn_local = 1'b1;
    tick();
    check_all_zero("reset");

    // 1 word, success
    issue_cmd(32'h0000_0050, 2'd0, {96'h0, 32'hDEAD_BEEF}, 1'b0, 1'b0);
    mbus_word(1);
    mbus_result(1'b1, 1'b0, 3'd1, 1'b0);

    // 4 words, success
    issue_cmd(32'h0000_1234, 2'd3,
              {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) mbus_word(1 + (i % 2));
    mbus_result(1'b1, 1'b0, 3'd4, 1'b0);

    // 4 words, TX_FAIL while word 3 is requested
    issue_cmd(32'h0000_00A0, 2'd3,
              {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 1'b0, 1'b0);
    mbus_word(1);
    mbus_word(1);
    check_eq("abort_req_pending", {63'b0, TX_REQ}, 64'h1);
    mbus_result(1'b0, 1'b1, 3'd2, 1'b1);

    // 2 words, TX_ACK held 5 cycles; both result lines high
    issue_cmd(32'h0000_0077, 2'd1, {64'h0, 32'h66, 32'h55}, 1'b0, 1'b0);
    mbus_word(5);
    mbus_word(1);
    mbus_result(1'b1, 1'b1, 3'd2, 1'b1);

    // priority, CMD_REQ held high after DONE
    issue_cmd(32'h0000_0090, 2'd0, {96'h0, 32'hCAFE_F00D}, 1'b1, 1'b1);
    mbus_word(1);
    mbus_result(1'b1, 1'b0, 3'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("no_retrigger", {63'b0, TX_REQ}, 64'h0);
    end
    check_eq("cmd_ack_held", {63'b0, CMD_ACK}, 64'h1);
    CMD_REQ = 1'b0;
    tick();
    check_eq("cmd_ack_fall", {63'b0, CMD_ACK}, 64'h0);
    issue_cmd(32'h0000_0091, 2'd0, {96'h0, 32'h0BAD_CAFE}, 1'b0, 1'b0);
    mbus_word(1);
    mbus_result(1'b1, 1'b0, 3'd1, 1'b0);

    // async reset while word 2 of 3 is requested
    issue_cmd(32'h0000_0033, 2'd2, {32'h0, 32'h99, 32'h88, 32'h77}, 1'b1, 1'b0);
    mbus_word(1);
    check_eq("pre_reset_req", {63'b0, TX_REQ}, 64'h1);
    resetn_local = 1'b0;
    #2;
    check_all_zero("async_reset");
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("reset_no_done", {63'b0, DONE}, 64'h0);
    end
    resetn_local = 1'b1;
    tick();
    check_eq("post_reset_idle", {61'b0, state_dbg}, 64'h0);
    issue_cmd(32'h0000_0044, 2'd1, {64'h0, 32'hA2, 32'hA1}, 1'b0, 1'b0);
    mbus_word(1);
    mbus_word(1);
    mbus_result(1'b1, 1'b0, 3'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
